// File: rtl/div_monitor.sv
// Divided-clock monitor: measures div_in period and high time, declares lock and flags errors.
// Optional saturating error counter is built when DIV_MONITOR_ERRCNT_EN is defined.
module div_monitor #(
  parameter int DIV      = 3,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DIV_V   = CNT_W'(DIV);
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic [3:0]       good_reg, good_next;
  logic             pend_reg, pend_next;
  logic             pv_reg, pv_next;
  logic             locked_reg, locked_next;
  logic             err_reg, err_next;

  logic             s2, s3, rise, fall;
  logic             cnt_sat, good_meas, measure, timeout;
  logic [3:0]       good_inc;

  assign s2        = sync_reg[1];
  assign s3        = sync_reg[2];
  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign cnt_sat   = (cnt_reg == CNT_MAX);
  assign good_meas = (cnt_reg == DIV_V);
  assign good_inc  = (good_reg == LOCK_V) ? good_reg : good_reg + 4'd1;
  // clr wins over any edge seen in the same cycle
  assign measure   = ~clr & rise & (state_reg != IDLE);
  assign timeout   = ~clr & ~rise & cnt_sat & (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (rise) state_next = MEAS;
        MEAS, LOCK: begin
          if (rise) begin
            if (!good_meas) state_next = MEAS;
            else if (good_inc == LOCK_V) state_next = LOCK;
          end else if (cnt_sat) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_next    = cnt_reg;
    hcnt_next   = hcnt_reg;
    period_next = period_reg;
    high_next   = high_reg;
    good_next   = good_reg;
    locked_next = locked_reg;
    pend_next   = measure;
    pv_next     = pend_reg & ~clr;
    err_next    = (measure & ~good_meas) | timeout;
    if (clr) begin
      cnt_next    = '0;
      hcnt_next   = '0;
      period_next = '0;
      high_next   = '0;
      good_next   = '0;
      locked_next = 1'b0;
    end else begin
      if (rise)         cnt_next = CNT_W'(1);
      else if (!cnt_sat) cnt_next = cnt_reg + CNT_W'(1);

      if (rise)                             hcnt_next = CNT_W'(1);
      else if (s2 && (hcnt_reg != CNT_MAX)) hcnt_next = hcnt_reg + CNT_W'(1);

      if (fall) high_next = hcnt_reg;

      if (measure) begin
        period_next = cnt_reg;
        good_next   = good_meas ? good_inc : 4'd0;
        locked_next = good_meas && (good_inc == LOCK_V);
      end else if (timeout) begin
        good_next   = '0;
        locked_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      period_reg <= '0;
      high_reg   <= '0;
      good_reg   <= '0;
      pend_reg   <= 1'b0;
      pv_reg     <= 1'b0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[1:0], div_in};
      cnt_reg    <= cnt_next;
      hcnt_reg   <= hcnt_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      good_reg   <= good_next;
      pend_reg   <= pend_next;
      pv_reg     <= pv_next;
      locked_reg <= locked_next;
      err_reg    <= err_next;
    end
  end

`ifdef DIV_MONITOR_ERRCNT_EN
  logic [7:0] errcnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errcnt_reg <= '0;
    end else if (clr) begin
      errcnt_reg <= '0;
    end else if (err_next && (errcnt_reg != 8'hFF)) begin
      errcnt_reg <= errcnt_reg + 8'd1;
    end
  end

  assign err_count = errcnt_reg;
`else
  assign err_count = '0;
`endif

  assign period       = period_reg;
  assign high_time    = high_reg;
  assign period_valid = pv_reg;
  assign locked       = locked_reg;
  assign err          = err_reg;

endmodule
